// File: rtl/mmio_pkg.sv
// mmio_pkg: shared definitions for the MMIO hub.
//   - status register bit positions and control bits of the status/control word
//   - decode selector enum used by the read mux
//   - address-range overlap helper used by the elaboration-time map check
package mmio_pkg;

  // Status word layout (read at STAT_ADDR)
  localparam int OVF_BIT   = 31;
  localparam int FULL_BIT  = 30;
  localparam int EMPTY_BIT = 29;

  // Control bits (store to STAT_ADDR)
  localparam int CLR_OVF = 0;
  localparam int FLUSH   = 1;

  // Which source answers the current processor address
  typedef enum logic [2:0] {
    SEL_RAM  = 3'd0,
    SEL_EVT  = 3'd1,
    SEL_STAT = 3'd2,
    SEL_WR   = 3'd3,
    SEL_RD   = 3'd4
  } sel_e;

  // True when [a_lo, a_lo+a_n) and [b_lo, b_lo+b_n) share any address
  function automatic logic ranges_overlap(input int a_lo, input int a_n,
                                          input int b_lo, input int b_n);
    return (a_lo < b_lo + b_n) && (b_lo < a_lo + a_n);
  endfunction

endpackage

// File: rtl/mmio_hub_evt_fifo.sv
// evt_fifo: button-event FIFO with sticky overflow flag.
// Ports:
//   clock, reset        rising-edge clock, async active-high reset
//   push, din           push request and code (dropped when full without pop)
//   pop                 pop request (ignored when empty)
//   flush               clears pointers/count; a same-cycle push is discarded
//   clr_ovf             clears the sticky overflow flag
//   head                oldest entry (meaningful only when !empty)
//   count, full, empty  occupancy
//   overflow            sticky: set when a push was dropped
module evt_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic             clr_ovf,
  input  logic [W-1:0]     din,
  output logic [W-1:0]     head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             overflow
);

  logic [W-1:0]     mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             ovf_r;

  logic full_s;
  logic empty_s;
  logic do_pop_s;
  logic do_push_s;
  logic ovf_set_s;

  // Accept/reject decisions; a pop frees the slot for a push on a full FIFO
  always_comb begin
    full_s    = (count_r == CNT_W'(DEPTH));
    empty_s   = (count_r == {CNT_W{1'b0}});
    do_pop_s  = pop && !empty_s && !flush;
    do_push_s = push && !flush && (!full_s || do_pop_s);
    ovf_set_s = push && !flush && full_s && !do_pop_s;
  end

  // Pointer and occupancy state; pointers wrap naturally (DEPTH is 2^n)
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Sticky overflow; a new drop in the clearing cycle keeps it set
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ovf_r <= 1'b0;
    end else if (ovf_set_s) begin
      ovf_r <= 1'b1;
    end else if (clr_ovf) begin
      ovf_r <= 1'b0;
    end else begin
      ovf_r <= ovf_r;
    end
  end

  // Entry storage
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= {W{1'b0}};
    end else if (do_push_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  assign head     = mem_r[rd_ptr_r];
  assign count    = count_r;
  assign full     = full_s;
  assign empty    = empty_s;
  assign overflow = ovf_r;

endmodule

// File: rtl/mmio_hub.sv
// mmio_hub: address decode between the processor data port and peripherals.
// Ports:
//   clock, reset          rising-edge clock, async active-high reset
//   wren, rden            store enable / one-cycle load strobe
//   address, data_in      processor address and store data
//   q_ram                 RAM read data (returned for unmapped addresses)
//   q_dmem                combinational read data back to the processor
//   rd_data               packed read-channel sources (channel k at RD_BASE+k)
//   wr_strobe, wr_data    registered one-cycle pulse and held value per channel
//   evt_valid, evt_code   event push into the FIFO (popped by loads of EVT_ADDR)
// If the read and write ranges overlap, the write channel read-back wins.
module mmio_hub import mmio_pkg::*; #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 32,
  parameter int N_RD       = 2,
  parameter int RD_BASE    = 5,
  parameter int N_WR       = 5,
  parameter int WR_BASE    = 6,
  parameter int EVT_ADDR   = 16,
  parameter int STAT_ADDR  = 17,
  parameter int FIFO_DEPTH = 8,
  parameter int EVT_W      = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   wren,
  input  logic                   rden,
  input  logic [ADDR_W-1:0]      address,
  input  logic [DATA_W-1:0]      data_in,
  input  logic [DATA_W-1:0]      q_ram,
  output logic [DATA_W-1:0]      q_dmem,
  input  logic [N_RD*DATA_W-1:0] rd_data,
  output logic [N_WR-1:0]        wr_strobe,
  output logic [N_WR*DATA_W-1:0] wr_data,
  input  logic                   evt_valid,
  input  logic [EVT_W-1:0]       evt_code
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  // Configuration checks: the single-address registers must not collide
  // with each other or with either channel range.
  if (ranges_overlap(EVT_ADDR, 1, STAT_ADDR, 1) ||
      ranges_overlap(EVT_ADDR, 1, WR_BASE, N_WR) ||
      ranges_overlap(EVT_ADDR, 1, RD_BASE, N_RD) ||
      ranges_overlap(STAT_ADDR, 1, WR_BASE, N_WR) ||
      ranges_overlap(STAT_ADDR, 1, RD_BASE, N_RD)) begin : g_bad_map
    $error("mmio_hub: overlapping address map");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("mmio_hub: FIFO_DEPTH must be a power of two >= 2");
  end
  if (DATA_W < 32 || DATA_W <= EVT_W) begin : g_bad_width
    $error("mmio_hub: DATA_W too narrow for status/event words");
  end

  sel_e                           sel_s;
  logic [N_WR-1:0]                wr_hit_s;
  logic [N_RD-1:0]                rd_hit_s;
  logic [N_WR-1:0]                wr_en_s;
  logic [DATA_W-1:0]              wr_rb_s;
  logic [DATA_W-1:0]              rd_mux_s;
  logic [DATA_W-1:0]              stat_s;
  logic [DATA_W-1:0]              evt_s;
  logic                           pop_s;
  logic                           flush_s;
  logic                           clr_ovf_s;
  logic [N_WR-1:0][DATA_W-1:0]    wr_data_r;
  logic [N_WR-1:0]                wr_strobe_r;

  logic [EVT_W-1:0] head_s;
  logic [CNT_W-1:0] count_s;
  logic             full_s;
  logic             empty_s;
  logic             ovf_s;

  // Address decode with fixed priority EVT > STAT > write range > read range
  always_comb begin
    wr_hit_s = {N_WR{1'b0}};
    rd_hit_s = {N_RD{1'b0}};
    for (int k = 0; k < N_WR; k++) wr_hit_s[k] = (address == ADDR_W'(WR_BASE + k));
    for (int k = 0; k < N_RD; k++) rd_hit_s[k] = (address == ADDR_W'(RD_BASE + k));
    if (address == ADDR_W'(EVT_ADDR)) begin
      sel_s = SEL_EVT;
    end else if (address == ADDR_W'(STAT_ADDR)) begin
      sel_s = SEL_STAT;
    end else if (|wr_hit_s) begin
      sel_s = SEL_WR;
    end else if (|rd_hit_s) begin
      sel_s = SEL_RD;
    end else begin
      sel_s = SEL_RAM;
    end
  end

  // Side-effect strobes derived from the decode
  always_comb begin
    wr_en_s   = (wren && sel_s == SEL_WR) ? wr_hit_s : {N_WR{1'b0}};
    pop_s     = rden && (sel_s == SEL_EVT);
    flush_s   = wren && (sel_s == SEL_STAT) && data_in[FLUSH];
    clr_ovf_s = wren && (sel_s == SEL_STAT) && data_in[CLR_OVF];
  end

  // Write-channel registers: one-cycle pulse, data held until rewritten
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_strobe_r <= {N_WR{1'b0}};
      wr_data_r   <= '0;
    end else begin
      wr_strobe_r <= wr_en_s;
      for (int k = 0; k < N_WR; k++) begin
        if (wr_en_s[k]) wr_data_r[k] <= data_in;
      end
    end
  end

  evt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (EVT_W)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (evt_valid),
    .pop      (pop_s),
    .flush    (flush_s),
    .clr_ovf  (clr_ovf_s),
    .din      (evt_code),
    .head     (head_s),
    .count    (count_s),
    .full     (full_s),
    .empty    (empty_s),
    .overflow (ovf_s)
  );

  // Candidate read words; hit vectors are one-hot so OR-ing selects one
  always_comb begin
    wr_rb_s  = {DATA_W{1'b0}};
    rd_mux_s = {DATA_W{1'b0}};
    for (int k = 0; k < N_WR; k++) begin
      if (wr_hit_s[k]) wr_rb_s = wr_rb_s | wr_data_r[k];
    end
    for (int k = 0; k < N_RD; k++) begin
      if (rd_hit_s[k]) rd_mux_s = rd_mux_s | rd_data[k*DATA_W +: DATA_W];
    end
    stat_s            = {DATA_W{1'b0}};
    stat_s[OVF_BIT]   = ovf_s;
    stat_s[FULL_BIT]  = full_s;
    stat_s[EMPTY_BIT] = empty_s;
    stat_s[CNT_W-1:0] = count_s;
    evt_s             = {DATA_W{1'b0}};
    if (!empty_s) begin
      evt_s[DATA_W-1]  = 1'b1;
      evt_s[EVT_W-1:0] = head_s;
    end else begin
      evt_s = {DATA_W{1'b0}};
    end
  end

  // Processor read mux
  always_comb begin
    case (sel_s)
      SEL_EVT:  q_dmem = evt_s;
      SEL_STAT: q_dmem = stat_s;
      SEL_WR:   q_dmem = wr_rb_s;
      SEL_RD:   q_dmem = rd_mux_s;
      SEL_RAM:  q_dmem = q_ram;
      default:  q_dmem = q_ram;
    endcase
  end

  assign wr_strobe = wr_strobe_r;
  assign wr_data   = wr_data_r;

endmodule

// File: tb/tb_mmio_hub.sv
// Self-checking bench for mmio_hub (default parameters).
module tb_mmio_hub;

  logic         clock = 1'b0;
  logic         reset;
  logic         wren;
  logic         rden;
  logic [11:0]  address;
  logic [31:0]  data_in;
  logic [31:0]  q_ram;
  logic [31:0]  q_dmem;
  logic [63:0]  rd_data;
  logic [4:0]   wr_strobe;
  logic [159:0] wr_data;
  logic         evt_valid;
  logic [3:0]   evt_code;

  always #5 clock = ~clock;

  mmio_hub dut (
    .clock     (clock),
    .reset     (reset),
    .wren      (wren),
    .rden      (rden),
    .address   (address),
    .data_in   (data_in),
    .q_ram     (q_ram),
    .q_dmem    (q_dmem),
    .rd_data   (rd_data),
    .wr_strobe (wr_strobe),
    .wr_data   (wr_data),
    .evt_valid (evt_valid),
    .evt_code  (evt_code)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: event queue, sticky overflow, held write values, pulse
  int unsigned evq[$];
  logic        m_ovf;
  logic [31:0] m_wr [5];
  logic [4:0]  m_strb;

  typedef struct {
    logic        we;
    logic        re;
    logic [11:0] a;
    logic [31:0] d;
    logic        ev;
    logic [3:0]  c;
    logic [31:0] exp_q;
    logic [4:0]  exp_s;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    s = 32'd0;
    s[31] = m_ovf;
    s[30] = (evq.size() == 8);
    s[29] = (evq.size() == 0);
    s[3:0] = 4'(evq.size());
    return s;
  endfunction

  function automatic logic [31:0] m_read(input logic [11:0] a, input logic [31:0] qr,
                                         input logic [63:0] rdd);
    int ai;
    ai = int'(a);
    if (ai == 16) return (evq.size() > 0) ? (32'h8000_0000 | 32'(evq[0])) : 32'd0;
    if (ai == 17) return m_status();
    if (ai >= 6 && ai <= 10) return m_wr[ai-6];
    if (ai == 5) return rdd[31:0];
    return qr;
  endfunction

  function automatic logic [159:0] m_pack();
    logic [159:0] p;
    for (int k = 0; k < 5; k++) p[k*32 +: 32] = m_wr[k];
    return p;
  endfunction

  task automatic m_reset();
    evq.delete();
    m_ovf  = 1'b0;
    m_strb = 5'd0;
    for (int k = 0; k < 5; k++) m_wr[k] = 32'd0;
  endtask

  task automatic m_edge(input logic we, input logic re, input logic [11:0] a,
                        input logic [31:0] d, input logic ev, input logic [3:0] c);
    int  ai;
    logic fl, clr, pop;
    ai  = int'(a);
    fl  = we && (ai == 17) && d[1];
    clr = we && (ai == 17) && d[0];
    pop = re && (ai == 16) && (evq.size() > 0);
    m_strb = 5'd0;
    if (we && ai >= 6 && ai <= 10) begin
      m_wr[ai-6] = d;
      m_strb = 5'b00001 << (ai - 6);
    end
    if (clr) m_ovf = 1'b0;
    if (fl) begin
      evq.delete();
    end else begin
      if (pop) void'(evq.pop_front());
      if (ev) begin
        if (evq.size() < 8) evq.push_back(int'(c));
        else m_ovf = 1'b1;
      end
    end
  endtask

  // One bus cycle: drive at posedge+1, check comb read, clock, check registers
  task automatic step(input logic we, input logic re, input logic [11:0] a,
                      input logic [31:0] d, input logic ev, input logic [3:0] c,
                      input logic [31:0] qr, input logic [63:0] rdd,
                      output logic [31:0] q_seen, output logic [4:0] s_seen);
    wren = we; rden = re; address = a; data_in = d;
    evt_valid = ev; evt_code = c; q_ram = qr; rd_data = rdd;
    #1;
    q_seen = q_dmem;
    chk("q_dmem_model", {128'd0, q_dmem}, {128'd0, m_read(a, qr, rdd)});
    @(posedge clock);
    m_edge(we, re, a, d, ev, c);
    #1;
    s_seen = wr_strobe;
    chk("wr_strobe_model", {155'd0, wr_strobe}, {155'd0, m_strb});
    chk("wr_data_model", wr_data, m_pack());
  endtask

  initial begin
    logic [31:0] qs;
    logic [4:0]  ss;
    logic [63:0] rdd_fix;
    logic [11:0] a;
    logic        we, re;
    logic [31:0] d;
    int          r;

    rdd_fix = 64'hCAFE_0001_1234_5678;
    reset = 1'b1; wren = 1'b0; rden = 1'b0; address = 12'd0; data_in = 32'd0;
    q_ram = 32'h0000_ABCD; rd_data = rdd_fix; evt_valid = 1'b0; evt_code = 4'd0;
    m_reset();
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    chk("reset_strobe", {155'd0, wr_strobe}, 160'd0);
    chk("reset_wr_data", wr_data, 160'd0);

    // Directed table
    tbl[0]  = '{1'b0, 1'b1, 12'd20, 32'd0, 1'b0, 4'd0, 32'h0000_ABCD, 5'b00000};
    tbl[1]  = '{1'b1, 1'b0, 12'd6,  32'd5, 1'b0, 4'd0, 32'h0000_0000, 5'b00001};
    tbl[2]  = '{1'b0, 1'b1, 12'd6,  32'd0, 1'b0, 4'd0, 32'h0000_0005, 5'b00000};
    tbl[3]  = '{1'b0, 1'b0, 12'd20, 32'd0, 1'b1, 4'd1, 32'h0000_ABCD, 5'b00000};
    tbl[4]  = '{1'b0, 1'b0, 12'd20, 32'd0, 1'b1, 4'd2, 32'h0000_ABCD, 5'b00000};
    tbl[5]  = '{1'b0, 1'b0, 12'd20, 32'd0, 1'b1, 4'd3, 32'h0000_ABCD, 5'b00000};
    tbl[6]  = '{1'b0, 1'b1, 12'd16, 32'd0, 1'b0, 4'd0, 32'h8000_0001, 5'b00000};
    tbl[7]  = '{1'b0, 1'b1, 12'd16, 32'd0, 1'b0, 4'd0, 32'h8000_0002, 5'b00000};
    tbl[8]  = '{1'b0, 1'b1, 12'd16, 32'd0, 1'b0, 4'd0, 32'h8000_0003, 5'b00000};
    tbl[9]  = '{1'b0, 1'b1, 12'd16, 32'd0, 1'b0, 4'd0, 32'h0000_0000, 5'b00000};
    tbl[10] = '{1'b0, 1'b1, 12'd17, 32'd0, 1'b0, 4'd0, 32'h2000_0000, 5'b00000};
    tbl[11] = '{1'b0, 1'b1, 12'd5,  32'd0, 1'b0, 4'd0, 32'h1234_5678, 5'b00000};
    for (int i = 0; i < 12; i++) begin
      step(tbl[i].we, tbl[i].re, tbl[i].a, tbl[i].d, tbl[i].ev, tbl[i].c,
           32'h0000_ABCD, rdd_fix, qs, ss);
      chk($sformatf("tbl%0d_q", i), {128'd0, qs}, {128'd0, tbl[i].exp_q});
      chk($sformatf("tbl%0d_strobe", i), {155'd0, ss}, {155'd0, tbl[i].exp_s});
    end

    // Overflow: nine pushes (codes 4..12) into depth 8
    for (int i = 0; i < 9; i++)
      step(1'b0, 1'b0, 12'd20, 32'd0, 1'b1, 4'(i + 4), 32'd0, rdd_fix, qs, ss);
    step(1'b0, 1'b1, 12'd17, 32'd0, 1'b0, 4'd0, 32'd0, rdd_fix, qs, ss);
    chk("ovf_status", {128'd0, qs}, {128'd0, 32'hC000_0008});
    step(1'b0, 1'b0, 12'd16, 32'd0, 1'b0, 4'd0, 32'd0, rdd_fix, qs, ss);
    chk("ovf_head", {128'd0, qs}, {128'd0, 32'h8000_0004});
    step(1'b1, 1'b0, 12'd17, 32'd1, 1'b0, 4'd0, 32'd0, rdd_fix, qs, ss);
    step(1'b0, 1'b1, 12'd17, 32'd0, 1'b0, 4'd0, 32'd0, rdd_fix, qs, ss);
    chk("ovf_cleared", {128'd0, qs}, {128'd0, 32'h4000_0008});

    // Full: push and pop together
    step(1'b0, 1'b1, 12'd16, 32'd0, 1'b1, 4'hE, 32'd0, rdd_fix, qs, ss);
    chk("full_pushpop_head", {128'd0, qs}, {128'd0, 32'h8000_0004});
    step(1'b0, 1'b1, 12'd17, 32'd0, 1'b0, 4'd0, 32'd0, rdd_fix, qs, ss);
    chk("full_pushpop_count", {128'd0, qs}, {128'd0, 32'h4000_0008});
    for (int i = 0; i < 8; i++)
      step(1'b0, 1'b1, 12'd16, 32'd0, 1'b0, 4'd0, 32'd0, rdd_fix, qs, ss);
    chk("full_pushpop_tail", {128'd0, qs}, {128'd0, 32'h8000_000E});

    // Reset in the middle of a strobe with three queued entries
    for (int i = 1; i <= 3; i++)
      step(1'b0, 1'b0, 12'd20, 32'd0, 1'b1, 4'(i), 32'd0, rdd_fix, qs, ss);
    step(1'b1, 1'b0, 12'd7, 32'h77, 1'b0, 4'd0, 32'd0, rdd_fix, qs, ss);
    chk("pre_reset_strobe", {155'd0, ss}, {155'd0, 5'b00010});
    wren = 1'b0;
    reset = 1'b1;
    #1;
    chk("async_reset_strobe", {155'd0, wr_strobe}, 160'd0);
    chk("async_reset_wr_data", wr_data, 160'd0);
    m_reset();
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    step(1'b0, 1'b1, 12'd17, 32'd0, 1'b0, 4'd0, 32'd0, rdd_fix, qs, ss);
    chk("post_reset_status", {128'd0, qs}, {128'd0, 32'h2000_0000});

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 9));
      case (r)
        0:       a = 12'd5;
        1:       a = 12'd6;
        2, 3:    a = 12'($urandom_range(6, 10));
        4, 5:    a = 12'd16;
        6:       a = 12'd17;
        default: a = 12'($urandom_range(18, 4095));
      endcase
      we = ($urandom_range(0, 2) == 0);
      re = !we && ($urandom_range(0, 2) != 0);
      d  = (a == 12'd17) ? 32'($urandom_range(0, 3)) : $urandom;
      step(we, re, a, d, ($urandom_range(0, 2) == 0), 4'($urandom_range(0, 15)),
           $urandom, {$urandom, $urandom}, qs, ss);
    end

    wren = 1'b0; rden = 1'b0; evt_valid = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
